ms_irq_dispatch: RTL
====================

Name: ms_irq_dispatch

Overview:
- Multi-core interrupt dispatcher for the multi-core processor top.
- Generalises the existing single busy-list/IRQ-to-process exchange to N cores and M lines.
- Supports per-line edge/level mode and masking, one-deep edge queuing, and round-robin core selection.
- Replaces the IRQ portion of the CPU controller: it latches IRQs, offers one to a free core, and tracks service until the ISR ends.

Parameters:
CCoreCnt, 2, number of cores served (1..16)
CIrqCnt, 8, number of IRQ lines (1..64)
CIrqIdxW, 3, width of an IRQ index, equal to ceil(log2(CIrqCnt)), minimum 1

Ports:
AClkH  in  1  system clock, rising edge
AResetHN  in  1  reset, asynchronous, active-low
AClkHEn  in  1  clock enable; all registers hold when 0
AExecEn  in  1  when 0, no new pending bits are set; existing state is kept
AIrq  in  CIrqCnt  raw asynchronous IRQ lines
AIrqMode  in  CIrqCnt  per line: 1 = rising-edge, 0 = level-high
AIrqMask  in  CIrqCnt  per line: 1 = enabled
ACoreIrqEn  in  CCoreCnt  core can accept an IRQ (interrupts enabled, not in ISR)
AIrqReq  out  CCoreCnt  IRQ offer to each core
AIrqIdx  out  CCoreCnt*CIrqIdxW  offered index; core c uses slice [c*CIrqIdxW +: CIrqIdxW]
AIrqAck  in  CCoreCnt  core accepts the current offer
AIrqDone  in  CCoreCnt  core finished its ISR (IRET)
AIrqBusyList  out  CIrqCnt  lines currently being serviced
APending  out  CIrqCnt  latched pending lines

Behaviour:
Reset (asynchronous, AResetHN=0):
- Synchronizers, pending, busy, offer state, AIrqReq, AIrqIdx and the RR pointer all clear to 0.
- All outputs are low while reset is asserted.

Clock enable:
- Every update below happens only on a rising AClkH edge with AClkHEn=1.
- With AClkHEn=0, all state and outputs hold, including the synchronizer flops.

Input path:
- Each AIrq bit passes through 2 sync flops (s1, s2) plus a history flop s3.
- Edge event: s2 & ~s3. Level event: s2.

Pending[i]:
- Set when (event for the selected mode) & AIrqMask[i] & AExecEn.
- Level mode: not set while busy[i] or offered[i].
- Edge mode: an edge while busy or offered sets pending, queued one deep; further edges merge.
- Cleared when an offer for line i is acked.
- If ack and a new set occur in the same cycle, set wins.
- Masking a line does not clear its pending bit; masked pending lines are not dispatched.

Per-core FSM, states FREE / OFFER / SERVICE:
- FREE -> OFFER: the core is the dispatch target this cycle. AIrqReq=1 and AIrqIdx is loaded at the same edge.
- OFFER:
  - AIrqReq and AIrqIdx are held stable.
  - On AIrqAck, go to SERVICE: busy[idx] is set and AIrqReq drops at that edge.
  - If ACoreIrqEn=0 and AIrqAck=0, withdraw: go to FREE, AIrqReq drops, the line stays pending.
- SERVICE -> FREE on AIrqDone: busy[idx] clears.
- AIrqAck outside OFFER and AIrqDone outside SERVICE are ignored.

Dispatch (at most one new offer per cycle):
- Eligible line: lowest index i with pending & mask & ~busy & ~offered.
- Target core: first core c with FREE & ACoreIrqEn, searched from rr_ptr upward with wrap-around.
- After an offer, rr_ptr becomes c+1 modulo CCoreCnt.
- No offer if no line or no core qualifies.
- A line freed by AIrqDone becomes eligible on the following cycle, not the same one.

Latency:
- AIrq first sampled high at edge k: s1 at k, s2 at k+1, pending at k+2, AIrqReq at k+3.
- AIrqIdx is valid in the same cycle as AIrqReq.

Outputs:
- AIrqBusyList = busy register.
- APending = pending register.
- AIrqIdx of a non-offering core holds its last value; it is meaningful only while AIrqReq is high.

Reset mid-operation:
- Asserting reset while in OFFER or SERVICE drops everything immediately.
- No ack or done is expected afterwards.

Test Plan:
1. CCoreCnt=2, CIrqCnt=8. Edge mode, all lines masked in, both cores enabled; pulse AIrq[5] for 1 cycle at edge 10 -> APending[5]=1 at edge 12; AIrqReq=2'b01, idx0=5 at edge 13; ack at 15 -> busy[5]=1, req low; done at 20 -> busy[5]=0.
2. AIrq[1] and AIrq[6] rise together -> line 1 offered to core 0, then line 6 to core 1 one cycle later; rr_ptr=0 afterwards.
3. Level mode on line 2, held high through service -> no re-pend while busy; after done it re-pends and is re-offered 1 cycle later. With AIrq[2] low before done -> no re-offer.
4. Edge mode on line 3: second edge during SERVICE -> APending[3]=1 while busy; re-offered the cycle after done. Three edges during service -> exactly one re-offer.
5. Core 0 in OFFER, ACoreIrqEn[0] dropped without ack -> req withdrawn, line stays pending, next offer goes to core 1. ACoreIrqEn=0 on all cores -> no AIrqReq ever.
6. AClkHEn=0 for 5 cycles with an offer active -> outputs frozen. AExecEn=0 while edges occur -> APending stays 0. AResetHN low mid-SERVICE -> all outputs 0 immediately.

Source files
------------

// File: rtl/ms_irq_dispatch_if.sv
// Offer/accept/done handshake between the IRQ dispatcher and the cores it serves.
// The dispatcher side is the master: it drives the offer, and the cores answer.
interface ms_irq_dispatch_if #(
    parameter int CCoreCnt = 2,
    parameter int CIrqIdxW = 3
);
    logic [CCoreCnt-1:0]          ACoreIrqEn;
    logic [CCoreCnt-1:0]          AIrqReq;
    logic [CCoreCnt*CIrqIdxW-1:0] AIrqIdx;
    logic [CCoreCnt-1:0]          AIrqAck;
    logic [CCoreCnt-1:0]          AIrqDone;

    modport master (
        input  ACoreIrqEn, AIrqAck, AIrqDone,
        output AIrqReq, AIrqIdx
    );

    modport slave (
        output ACoreIrqEn, AIrqAck, AIrqDone,
        input  AIrqReq, AIrqIdx
    );
endinterface

// File: rtl/ms_irq_dispatch.sv
// Multi-core interrupt dispatcher: synchronises IRQ lines, latches pending lines,
// offers the lowest eligible line to a free core in round-robin order and tracks service.
module ms_irq_dispatch #(
    parameter int CCoreCnt = 2,
    parameter int CIrqCnt  = 8,
    parameter int CIrqIdxW = 3
) (
    input  logic                AClkH,
    input  logic                AResetHN,
    input  logic                AClkHEn,
    input  logic                AExecEn,
    input  logic [CIrqCnt-1:0]  AIrq,
    input  logic [CIrqCnt-1:0]  AIrqMode,
    input  logic [CIrqCnt-1:0]  AIrqMask,
    ms_irq_dispatch_if.master   ACore,
    output logic [CIrqCnt-1:0]  AIrqBusyList,
    output logic [CIrqCnt-1:0]  APending
);
    localparam int CRrW = (CCoreCnt > 1) ? $clog2(CCoreCnt) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_OFFER, ST_SERVICE} state_e;

    logic [CIrqCnt-1:0]  s1_q, s2_q, s3_q;
    logic [CIrqCnt-1:0]  pending_q, pending_d;
    logic [CIrqCnt-1:0]  busy_q, busy_d;
    state_e              state_q [CCoreCnt];
    state_e              state_d [CCoreCnt];
    logic [CIrqIdxW-1:0] idx_q [CCoreCnt];
    logic [CIrqIdxW-1:0] idx_d [CCoreCnt];
    logic [CCoreCnt-1:0] req_q, req_d;
    logic [CRrW-1:0]     rr_q, rr_d;

    logic [CIrqCnt-1:0]  offered, ack_clr, event_v, set_v;
    logic                line_ok, core_ok;
    logic [CIrqIdxW-1:0] line_sel;
    logic [CRrW-1:0]     core_sel;

    always_comb begin
        offered = '0;
        ack_clr = '0;
        for (int c = 0; c < CCoreCnt; c++) begin
            if (state_q[c] == ST_OFFER) begin
                offered[idx_q[c]] = 1'b1;
                if (ACore.AIrqAck[c]) ack_clr[idx_q[c]] = 1'b1;
            end
        end
    end

    // Level lines are suppressed while in flight; edge lines queue one deep instead.
    always_comb begin
        event_v   = (AIrqMode & s2_q & ~s3_q) | (~AIrqMode & s2_q);
        set_v     = event_v & AIrqMask & {CIrqCnt{AExecEn}} & (AIrqMode | ~(busy_q | offered));
        pending_d = (pending_q & ~ack_clr) | set_v;
    end

    always_comb begin
        line_ok  = 1'b0;
        line_sel = '0;
        for (int i = CIrqCnt - 1; i >= 0; i--) begin
            if (pending_q[i] && AIrqMask[i] && !busy_q[i] && !offered[i]) begin
                line_ok  = 1'b1;
                line_sel = CIrqIdxW'(i);
            end
        end
        core_ok  = 1'b0;
        core_sel = '0;
        for (int k = CCoreCnt - 1; k >= 0; k--) begin
            if (state_q[(int'(rr_q) + k) % CCoreCnt] == ST_FREE &&
                ACore.ACoreIrqEn[(int'(rr_q) + k) % CCoreCnt]) begin
                core_ok  = 1'b1;
                core_sel = CRrW'((int'(rr_q) + k) % CCoreCnt);
            end
        end
    end

    always_comb begin
        busy_d = busy_q;
        req_d  = req_q;
        rr_d   = rr_q;
        for (int c = 0; c < CCoreCnt; c++) begin
            state_d[c] = state_q[c];
            idx_d[c]   = idx_q[c];
            case (state_q[c])
                ST_FREE: begin
                    if (line_ok && core_ok && core_sel == CRrW'(c)) begin
                        state_d[c] = ST_OFFER;
                        idx_d[c]   = line_sel;
                        req_d[c]   = 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (ACore.AIrqAck[c]) begin
                        state_d[c]        = ST_SERVICE;
                        busy_d[idx_q[c]]  = 1'b1;
                        req_d[c]          = 1'b0;
                    end else if (!ACore.ACoreIrqEn[c]) begin
                        state_d[c] = ST_FREE;
                        req_d[c]   = 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (ACore.AIrqDone[c]) begin
                        state_d[c]       = ST_FREE;
                        busy_d[idx_q[c]] = 1'b0;
                    end
                end
                default: state_d[c] = ST_FREE;
            endcase
        end
        if (line_ok && core_ok) begin
            rr_d = (core_sel == CRrW'(CCoreCnt - 1)) ? '0 : core_sel + 1'b1;
        end
    end

    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            pending_q <= '0;
            busy_q    <= '0;
            req_q     <= '0;
            rr_q      <= '0;
            for (int c = 0; c < CCoreCnt; c++) begin
                state_q[c] <= ST_FREE;
                idx_q[c]   <= '0;
            end
        end else if (AClkHEn) begin
            s1_q      <= AIrq;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            req_q     <= req_d;
            rr_q      <= rr_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        ACore.AIrqIdx = '0;
        for (int c = 0; c < CCoreCnt; c++) begin
            ACore.AIrqIdx[c*CIrqIdxW +: CIrqIdxW] = idx_q[c];
        end
    end

    assign ACore.AIrqReq = req_q;
    assign AIrqBusyList  = busy_q;
    assign APending      = pending_q;
endmodule
